// File: rtl/button_event_pkg.sv
// Shared helpers for the button event block: counter sizing.
package button_event_pkg;

    // Number of bits needed to hold a non-negative value (minimum 1).
    function automatic int wordlength(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((value >>> i) != 0) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/button_event.sv
// Turns a debounced button level into one-clk event pulses:
// press, release, click, long press and auto-repeat while held.
// The ports "release" and "repeat" are SystemVerilog reserved words,
// so they carry a _pulse suffix here.
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_MAX   = 49,
    parameter int REPEAT_MAX = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic btn,
    output logic press,
    output logic release_pulse,
    output logic click,
    output logic long_press,
    output logic repeat_pulse,
    output logic held
);

    localparam int CNT_MAX = (LONG_MAX > REPEAT_MAX) ? LONG_MAX : REPEAT_MAX;
    localparam int CNT_W   = wordlength(CNT_MAX);

    localparam logic [CNT_W-1:0] LONG_CNT   = CNT_W'(LONG_MAX);
    localparam logic [CNT_W-1:0] REPEAT_CNT = CNT_W'(REPEAT_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHORT = 2'd1,
        S_LONG  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] counter_reg, counter_next;
    logic             btn_q;
    logic             press_reg, press_next;
    logic             release_reg, release_next;
    logic             click_reg, click_next;
    logic             long_reg, long_next;
    logic             repeat_reg, repeat_next;
    logic             held_reg, held_next;

    logic rise;
    logic fall;

    assign rise = btn & ~btn_q;
    assign fall = ~btn & btn_q;

    // State, counter, edge register and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            counter_reg <= '0;
            btn_q       <= 1'b0;
            press_reg   <= 1'b0;
            release_reg <= 1'b0;
            click_reg   <= 1'b0;
            long_reg    <= 1'b0;
            repeat_reg  <= 1'b0;
            held_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            counter_reg <= counter_next;
            btn_q       <= btn;
            press_reg   <= press_next;
            release_reg <= release_next;
            click_reg   <= click_next;
            long_reg    <= long_next;
            repeat_reg  <= repeat_next;
            held_reg    <= held_next;
        end
    end

    // Next-state and pulse decode; fall always wins over a coincident en tick.
    always_comb begin
        state_next   = state_reg;
        counter_next = counter_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        click_next   = 1'b0;
        long_next    = 1'b0;
        repeat_next  = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (rise) begin
                    state_next   = S_SHORT;
                    press_next   = 1'b1;
                    counter_next = '0;
                end
            end
            S_SHORT: begin
                if (fall) begin
                    state_next   = S_IDLE;
                    release_next = 1'b1;
                    click_next   = 1'b1;
                end else if (en) begin
                    if (counter_reg == LONG_CNT) begin
                        state_next   = S_LONG;
                        long_next    = 1'b1;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_reg + CNT_W'(1);
                    end
                end
            end
            S_LONG: begin
                if (fall) begin
                    state_next   = S_IDLE;
                    release_next = 1'b1;
                end else if (en) begin
                    if (counter_reg == REPEAT_CNT) begin
                        repeat_next  = 1'b1;
                        counter_next = '0;
                    end else begin
                        counter_next = counter_reg + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_next   = S_IDLE;
                counter_next = '0;
            end
        endcase

        held_next = (state_next != S_IDLE);
    end

    assign press         = press_reg;
    assign release_pulse = release_reg;
    assign click         = click_reg;
    assign long_press    = long_reg;
    assign repeat_pulse  = repeat_reg;
    assign held          = held_reg;

endmodule

// File: tb/tb_button_event.sv
// Randomized self-checking bench for button_event. Two instances share btn
// and reset: A (LONG_MAX=3, REPEAT_MAX=1, en every 4th clk or random) and
// B (LONG_MAX=3, REPEAT_MAX=0, en tied high).
module tb_button_event;

    localparam int A_LONG = 3;
    localparam int A_REP  = 1;
    localparam int B_LONG = 3;
    localparam int B_REP  = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, btn, en_a, en_b;
    logic a_press, a_release, a_click, a_long, a_repeat, a_held;
    logic b_press, b_release, b_click, b_long, b_repeat, b_held;

    button_event #(.LONG_MAX(A_LONG), .REPEAT_MAX(A_REP)) dut_a (
        .clk(clk), .reset(reset), .en(en_a), .btn(btn),
        .press(a_press), .release_pulse(a_release), .click(a_click),
        .long_press(a_long), .repeat_pulse(a_repeat), .held(a_held)
    );

    button_event #(.LONG_MAX(B_LONG), .REPEAT_MAX(B_REP)) dut_b (
        .clk(clk), .reset(reset), .en(en_b), .btn(btn),
        .press(b_press), .release_pulse(b_release), .click(b_click),
        .long_press(b_long), .repeat_pulse(b_repeat), .held(b_held)
    );

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    string phase       = "init";

    // Reference model: whether a hold is in progress and how many en ticks
    // have been counted since the press; events follow from that tick count.
    bit         prev_btn;
    bit         holding [2];
    int         ticks   [2];
    logic [5:0] exp_out [2];   // {press, release, click, long, repeat, held}

    task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s/%s cyc=%0d: got %b expected %b (press,rel,click,long,rep,held)",
                     phase, tag, cyc, got, want);
        end
    endtask

    task automatic model_update(input bit b, input bit r, input bit ea, input bit eb);
        for (int i = 0; i < 2; i++) begin
            int  lmax, rmax;
            bit  e, rise, fall;
            logic [5:0] o;
            lmax = (i == 0) ? A_LONG : B_LONG;
            rmax = (i == 0) ? A_REP  : B_REP;
            e    = (i == 0) ? ea : eb;
            o    = '0;
            rise = b & ~prev_btn;
            fall = ~b & prev_btn;
            if (r) begin
                holding[i] = 0;
                ticks[i]   = 0;
            end else if (!holding[i]) begin
                if (rise) begin
                    o[5]       = 1'b1;
                    holding[i] = 1;
                    ticks[i]   = 0;
                end
            end else if (fall) begin
                o[4]       = 1'b1;
                o[3]       = (ticks[i] <= lmax);
                holding[i] = 0;
            end else if (e) begin
                ticks[i]++;
                if (ticks[i] == lmax + 1)
                    o[2] = 1'b1;
                else if (ticks[i] > lmax + 1 && ((ticks[i] - lmax - 1) % (rmax + 1)) == 0)
                    o[1] = 1'b1;
            end
            o[0]       = r ? 1'b0 : holding[i];
            exp_out[i] = o;
        end
        prev_btn = r ? 1'b0 : b;
    endtask

    // One clk: check last edge's outputs, drive new inputs, advance the model.
    task automatic step(input bit b, input bit r, input bit rand_en);
        @(negedge clk);
        check_eq("a", {a_press, a_release, a_click, a_long, a_repeat, a_held}, exp_out[0]);
        check_eq("b", {b_press, b_release, b_click, b_long, b_repeat, b_held}, exp_out[1]);
        cyc++;
        en_a  = rand_en ? 1'($urandom_range(0, 1)) : ((cyc % 4) == 0);
        en_b  = 1'b1;
        btn   = b;
        reset = r;
        model_update(b, r, en_a, en_b);
    endtask

    task automatic repeat_step(input int n, input bit b, input bit r, input bit rand_en);
        for (int k = 0; k < n; k++) step(b, r, rand_en);
    endtask

    initial begin
        reset = 1'b1;
        btn   = 1'b0;
        en_a  = 1'b0;
        en_b  = 1'b1;
        prev_btn = 0;
        model_update(1'b0, 1'b1, 1'b0, 1'b1);

        phase = "reset";
        repeat_step(5, 0, 1, 0);
        $display("phase %s: 5 clk reset, btn low", phase);

        phase = "idle";
        repeat_step(20, 0, 0, 0);
        $display("phase %s: 20 clk btn low", phase);

        phase = "short";
        repeat_step(6, 1, 0, 0);
        repeat_step(6, 0, 0, 0);
        $display("phase %s: 6 clk press then release", phase);

        phase = "long";
        repeat_step(40, 1, 0, 0);
        repeat_step(8, 0, 0, 0);
        $display("phase %s: 40 clk hold then release", phase);

        phase = "one_clk";
        repeat_step(1, 1, 0, 0);
        repeat_step(4, 0, 0, 0);
        $display("phase %s: single clk button pulse", phase);

        phase = "fall_on_tick";
        step(1, 0, 0);
        begin
            int guard;
            guard = 0;
            while (!(ticks[0] == A_LONG && ((cyc + 1) % 4) == 0) && guard < 100) begin
                step(1, 0, 0);
                guard++;
            end
            vectors++;
            if (guard >= 100) begin
                miscompares++;
                $display("FAIL fall_on_tick: alignment not reached, got %0d ticks required %0d",
                         ticks[0], A_LONG);
            end
        end
        repeat_step(6, 0, 0, 0);
        $display("phase %s: release coincident with 4th tick", phase);

        phase = "reset_long";
        repeat_step(30, 1, 0, 0);
        repeat_step(3, 1, 1, 0);
        repeat_step(24, 1, 0, 0);
        repeat_step(5, 0, 0, 0);
        $display("phase %s: reset asserted during long hold", phase);

        phase = "random";
        for (int h = 0; h < 60; h++) begin
            int  hold_len, gap_len;
            bit  rmode;
            hold_len = $urandom_range(1, 50);
            gap_len  = $urandom_range(1, 8);
            rmode    = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) begin
                repeat_step(hold_len / 2 + 1, 1, 0, rmode);
                repeat_step($urandom_range(1, 3), 1'($urandom_range(0, 1)), 1, rmode);
                repeat_step(hold_len / 2 + 1, 1, 0, rmode);
            end else begin
                repeat_step(hold_len, 1, 0, rmode);
            end
            repeat_step(gap_len, 0, 0, rmode);
            $display("hold %0d: len=%0d gap=%0d random_en=%0d", h, hold_len, gap_len, rmode);
        end

        step(0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
